// File: rtl/au_pkg.sv
// -----------------------------------------------------------------------------
// au_pkg
//   Shared definitions for the 6-bit add/sub arithmetic unit and the blocks that
//   consume its results.
//   Contents:
//     AU_WIDTH                       datapath width of the AU sum
//     FLAG_Z/FLAG_N/FLAG_C/FLAG_V    bit positions inside au_flags_t
//     au_flags_t                     4-bit flag vector {V,C,N,Z}
// -----------------------------------------------------------------------------
package au_pkg;

  localparam int AU_WIDTH = 6;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef logic [3:0] au_flags_t;

endpackage : au_pkg

// File: rtl/au_flag_calc.sv
// -----------------------------------------------------------------------------
// au_flag_calc
//   Purely combinational derivation of the Z/N/C/V flags for one AU result.
//   Reusable by any consumer of the AU output.
//   Ports:
//     sum    in   WIDTH  AU sum
//     cout   in   1      carry out of the MSB stage (for subtract: 1 = no borrow)
//     sub    in   1      subtract select used for this result
//     a_msb  in   1      MSB of operand a
//     b_msb  in   1      MSB of operand b before inversion
//     flags  out  4      {V,C,N,Z}
// -----------------------------------------------------------------------------
module au_flag_calc
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             sub,
  input  logic             a_msb,
  input  logic             b_msb,
  output au_flags_t        flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (sum == '0);
    flags[FLAG_N] = sum[WIDTH-1];
    flags[FLAG_C] = cout;
    // The adder sees b inverted when subtracting, so the effective b sign is
    // b_msb ^ sub. Overflow: both effective operands share a sign and the
    // result sign differs from it.
    flags[FLAG_V] = (a_msb == (b_msb ^ sub)) && (sum[WIDTH-1] != a_msb);
  end

endmodule : au_flag_calc

// File: rtl/au_result_stage.sv
// -----------------------------------------------------------------------------
// au_result_stage
//   Registered result stage behind the combinational add/sub AU. Computes the
//   flags at push time and buffers {sum, flags} in a DEPTH-entry FIFO.
//   Optional feature macro: AU_RESULT_STICKY_EN (sticky overflow flag).
//   Ports:
//     clk         in   1      clock, rising edge
//     rst_n       in   1      asynchronous active-low reset
//     in_valid    in   1      AU result presented
//     in_ready    out  1      stage can accept (count < DEPTH)
//     in_sum      in   WIDTH  AU sum
//     in_cout     in   1      AU carry out
//     in_sub      in   1      AU subtract select
//     in_a_msb    in   1      MSB of operand a
//     in_b_msb    in   1      MSB of operand b before inversion
//     out_valid   out  1      head entry valid
//     out_ready   in   1      consumer accepts head entry
//     out_sum     out  WIDTH  head result (holds last value when empty)
//     out_flags   out  4      {V,C,N,Z} of head (holds last value when empty)
//     sticky_v    out  1      sticky overflow       (AU_RESULT_STICKY_EN only)
//     clr_sticky  in   1      clear sticky overflow (AU_RESULT_STICKY_EN only)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on registered count (no path from out_ready), so
// a full FIFO refuses a push even when a pop happens in the same cycle.
// Producers hold in_* stable while in_valid && !in_ready; out_* stay stable
// while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module au_result_stage
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_sub,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
`ifdef AU_RESULT_STICKY_EN
  output logic             sticky_v,
  input  logic             clr_sticky,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output au_flags_t        out_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_sum   [DEPTH];
  au_flags_t        mem_flags [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  au_flags_t        in_flags;

  au_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .sum   (in_sum),
    .cout  (in_cout),
    .sub   (in_sub),
    .a_msb (in_a_msb),
    .b_msb (in_b_msb),
    .flags (in_flags)
  );

  assign in_ready  = (count != DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr]   <= in_sum;
      mem_flags[wr_ptr] <= in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Output register tracks the head entry for the next cycle. When the new
  // head slot is the one being written right now, its data comes straight
  // from the input. When the FIFO goes empty the register simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_flags <= '0;
    end else if (count_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        out_sum   <= in_sum;
        out_flags <= in_flags;
      end else begin
        out_sum   <= mem_sum[rd_ptr_nxt];
        out_flags <= mem_flags[rd_ptr_nxt];
      end
    end
  end

`ifdef AU_RESULT_STICKY_EN
  // Setting has priority over clearing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
    end else if (push && in_flags[FLAG_V]) begin
      sticky_v <= 1'b1;
    end else if (clr_sticky) begin
      sticky_v <= 1'b0;
    end
  end
`endif

endmodule : au_result_stage

// File: tb/tb_au_result_stage.sv
// -----------------------------------------------------------------------------
// tb_au_result_stage
//   Directed bench for au_result_stage (WIDTH=6, DEPTH=2). Inputs are driven
//   1 time unit after the rising edge; outputs are sampled at that same point,
//   i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_au_result_stage;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_sub;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
`ifdef AU_RESULT_STICKY_EN
  logic             sticky_v;
  logic             clr_sticky;
`endif

  int checks;
  int errors;
  logic [WIDTH-1:0] exp_q[$];

  au_result_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .in_sub     (in_sub),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
`ifdef AU_RESULT_STICKY_EN
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic co,
                       input logic sb, input logic am, input logic bm);
    in_valid = v;
    in_sum   = s;
    in_cout  = co;
    in_sub   = sb;
    in_a_msb = am;
    in_b_msb = bm;
  endtask

  // Push one result with out_ready=1, check it one cycle later, let it pop,
  // and check the stage goes empty while holding the last value.
  task automatic push_check(input string tag, input logic [WIDTH-1:0] s, input logic co,
                            input logic sb, input logic am, input logic bm,
                            input logic [3:0] exp_flags);
    drive(1'b1, s, co, sb, am, bm);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_sum"},   {2'd0, out_sum},   {2'd0, s});
    check({tag, "_flags"}, {4'd0, out_flags}, {4'd0, exp_flags});
    tick();
    check({tag, "_empty"}, {7'd0, out_valid}, 8'd0);
    check({tag, "_hold"},  {2'd0, out_sum},   {2'd0, s});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef AU_RESULT_STICKY_EN
    clr_sticky = 1'b0;
`endif
    tick();
    tick();

    // reset state
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_sum",   {2'd0, out_sum},   8'd0);
    check("rst_flags", {4'd0, out_flags}, 8'd0);
    check("rst_ready", {7'd0, in_ready},  8'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {7'd0, out_valid}, 8'd0);

    out_ready = 1'b1;
    // 1: plain add
    push_check("add",     6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    // 2: subtract without borrow
    push_check("sub",     6'b000101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    // 3: positive overflow on add
    push_check("ovf_add", 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    // 4: zero result from subtract
    push_check("zero",    6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101);
    // negative overflow on subtract: -32 - 1
    push_check("ovf_sub", 6'b011111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100);
    // same-sign add, no overflow: -1 + -1 = -2
    push_check("neg_add", 6'b111110, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110);

`ifdef AU_RESULT_STICKY_EN
    check("sticky_set", {7'd0, sticky_v}, 8'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_clr", {7'd0, sticky_v}, 8'd0);
    // clear and V=1 push in the same cycle: set wins
    clr_sticky = 1'b1;
    drive(1'b1, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    clr_sticky = 1'b0;
    in_valid   = 1'b0;
    check("sticky_set_wins", {7'd0, sticky_v}, 8'd1);
    tick();
`endif

    // 5: fill with out_ready low, third push refused, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(6'b000001);
    tick();
    drive(1'b1, 6'b111110, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(6'b111110);
    tick();
    drive(1'b1, 6'b010101, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_ready", {7'd0, in_ready}, 8'd0);
    check("full_head",  {2'd0, out_sum},  {2'd0, exp_q[0]});
    tick();
    check("full_refused_ready", {7'd0, in_ready}, 8'd0);
    check("full_refused_head",  {2'd0, out_sum},  {2'd0, exp_q[0]});
    check("full_head_flags",    {4'd0, out_flags}, 8'h00);
    // pop while full: push still refused this edge
    out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    check("pop_full_head",  {2'd0, out_sum},   {2'd0, exp_q[0]});
    check("pop_full_flags", {4'd0, out_flags}, 8'h02);
    check("pop_full_ready", {7'd0, in_ready},  8'd1);
    // simultaneous push and pop with one entry queued
    exp_q.push_back(6'b010101);
    tick();
    void'(exp_q.pop_front());
    in_valid = 1'b0;
    check("pp_valid", {7'd0, out_valid}, 8'd1);
    check("pp_head",  {2'd0, out_sum},   {2'd0, exp_q[0]});
    check("pp_ready", {7'd0, in_ready},  8'd1);
    tick();
    void'(exp_q.pop_front());
    check("drain_empty", {7'd0, out_valid}, 8'd0);
    check("drain_queue", 8'(exp_q.size()), 8'd0);

    // 6: reset with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 6'b000011, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", {7'd0, out_valid}, 8'd1);
    check("pre_rst_ready", {7'd0, in_ready},  8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_sum",   {2'd0, out_sum},   8'd0);
    check("mid_rst_flags", {4'd0, out_flags}, 8'd0);
`ifdef AU_RESULT_STICKY_EN
    check("mid_rst_sticky", {7'd0, sticky_v}, 8'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_ready", {7'd0, in_ready},  8'd1);
    check("rel_valid", {7'd0, out_valid}, 8'd0);

    // stage works normally after reset
    out_ready = 1'b1;
    push_check("after_rst", 6'b101010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_au_result_stage
